data_mem_sync: RTL
==================

// Module: data_mem_sync
// PURPOSE
//   Clocked, parametrised word memory with a valid/ready request port and a valid/ready response port.
//   Supports byte-lane writes and a programmable access latency.
//   One access is outstanding at a time.
//   Serves as the data memory of the MIPS core, replacing the combinational level-sensitive RAM model.
// PARAMETERS
//   DATA_W   32   word width in bits; must be a multiple of 8
//   ADDR_W   8    word-address width
//   DEPTH    256  number of words; 1..2**ADDR_W, need not be a power of 2
//   LATENCY  1    cycles from the accept edge to rsp_valid; range 1..15
// PORTS
//   clk        in   1         clock; rising edge
//   rst_n      in   1         asynchronous active-low reset
//   req_valid  in   1         request present
//   req_ready  out  1         block can accept a request
//   req_we     in   1         1 = write, 0 = read
//   req_be     in   DATA_W/8  byte-lane write enables; bit k controls bits [8k+7:8k]
//   req_addr   in   ADDR_W    word address
//   req_wdata  in   DATA_W    write data
//   rsp_valid  out  1         response present
//   rsp_ready  in   1         consumer takes the response
//   rsp_rdata  out  DATA_W    read data; for a write, the word after the merge
//   rsp_err    out  1         access error; only driven when MEM_RANGE_CHECK_EN is defined, tied 0 otherwise
// BEHAVIOUR
//   Array init: at time 0, ram[i] = i*10+1, truncated to DATA_W. Reset does not touch the array.
//   Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//   FSM states:
//     IDLE: req_ready=1. On req_valid at a rising edge the request is accepted.
//       Write: each lane with req_be[k]=1 is written into ram[a]; other lanes keep their value.
//       The response word (merged word for a write, ram[a] for a read) is captured into rsp_rdata on that same edge.
//       Next state: RESP if LATENCY==1, else WAIT with cnt=LATENCY-1.
//     WAIT: req_ready=0. cnt decrements by 1 each cycle; at cnt==1 the next state is RESP.
//     RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready=1 at an edge; then go to IDLE.
//       req_ready=0 in RESP. There is no same-cycle turnaround, so back-to-back access costs LATENCY+1 cycles.
//   Latency: rsp_valid rises exactly LATENCY cycles after the accept edge.
//   Ordering: a later write never changes an already captured response.
//     A read that follows a write to the same address returns the merged data.
//   Write with req_be=0: legal; the array is unchanged and the response returns the current word.
//   Address a = req_addr when req_addr < DEPTH.
//     When req_addr >= DEPTH the handling is set by CONFIGURATION.
//   req_* inputs are sampled only at the accept edge and ignored at all other times.
//   rsp_ready is ignored outside RESP.
//   Reset mid-operation: the pending response is dropped.
//     A write already performed at the accept edge stays in the array.
// CONFIGURATION
//   MEM_RANGE_CHECK_EN
//     Defined: a request with req_addr >= DEPTH performs no write, returns rsp_rdata=0 and rsp_err=1.
//       It keeps the same LATENCY and the same handshake as any other access.
//       In-range accesses return rsp_err=0.
//     Undefined: a = req_addr % DEPTH (address wraps), and rsp_err is constant 0.
// TESTING
//   T1 reset+init: rst_n=0 then 1; read addr 5 with LATENCY=1 -> rsp_valid one cycle after accept, rsp_rdata=51, rsp_err=0.
//   T2 byte write: write addr 3, be=4'b0101, wdata=32'hAABBCCDD over init 31 (32'h1F).
//     -> rsp_rdata=32'h00BB00DD; a following read of addr 3 returns 32'h00BB00DD.
//   T3 latency+backpressure: LATENCY=4, read addr 0, hold rsp_ready=0 for 3 cycles.
//     -> rsp_valid rises 4 cycles after accept; rsp_rdata=1 held stable; req_ready=0 until the cycle after rsp_ready=1.
//   T4 range: DEPTH=200, read addr 210.
//     With MEM_RANGE_CHECK_EN: rsp_err=1, rsp_rdata=0.
//     Without: rsp_rdata=ram[10]=101, rsp_err=0.
//   T5 reset mid-op: LATENCY=3, write addr 7 with wdata=32'h12345678, be=4'hF; assert rst_n=0 in WAIT.
//     -> rsp_valid=0 and req_ready=1 after release; a read of addr 7 returns 32'h12345678.
//   T6 back-to-back: 8 consecutive reads with rsp_ready tied 1 and LATENCY=1.
//     -> one response every 2 cycles, data = addr*10+1, no drops or duplicates.

Source files
------------

// File: rtl/data_mem_sync.sv
// data_mem_sync: clocked word memory with valid/ready request and response ports.
// One access is outstanding at a time. The word is merged and captured on the accept
// edge, and it is presented LATENCY cycles later.
// Optional feature macro: MEM_RANGE_CHECK_EN. When it is defined, an address >= DEPTH
// returns rsp_err=1. When it is undefined, the address wraps modulo DEPTH.
module data_mem_sync #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int              NB      = DATA_W / 8;
  localparam logic [1:0]      S_IDLE  = 2'd0;
  localparam logic [1:0]      S_WAIT  = 2'd1;
  localparam logic [1:0]      S_RESP  = 2'd2;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_M1  = 4'(LATENCY - 1);

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  // Power-up contents: word i holds i*10+1, truncated to the word width.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = DATA_W'(i * 10 + 1);
    end
    return m;
  endfunction

  mem_t ram = init_mem();

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              addr_ok;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] merged;

  assign accept    = (state == S_IDLE) && req_valid;
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;

  // An out-of-range address is flagged, and it never reaches the array.
  assign addr_ok = ({1'b0, req_addr} < DEPTH_L);
  assign addr_a  = addr_ok ? req_addr : '0;
  assign rsp_err = err_q;

  // Capture the error flag with the response word on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= !addr_ok;
    end
  end
`else
  // The address wraps modulo DEPTH, so every request maps onto a real word.
  assign addr_ok = 1'b1;
  assign addr_a  = ADDR_W'({1'b0, req_addr} % DEPTH_L);
  assign rsp_err = 1'b0;
`endif

  assign cur_word = ram[addr_a];

  // Byte-lane merge: lanes with their enable set take new data, and the rest keep the stored word.
  always_comb begin
    merged = cur_word;
    for (int k = 0; k < NB; k++) begin
      if (req_we && req_be[k]) begin
        merged[8*k +: 8] = req_wdata[8*k +: 8];
      end
    end
  end

  // Storage write on the accept edge. Reset leaves the array contents intact.
  always_ff @(posedge clk) begin
    if (accept && addr_ok && req_we) begin
      ram[addr_a] <= merged;
    end
  end

  // Access FSM: accept, count down the latency, then hold the response until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rdata_q <= addr_ok ? merged : '0;
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
